// File: rtl/cache_pkg.sv
// cache_pkg: shared widths, controller state encoding and address-field helper for the caches
//   ADDR_WIDTH   : byte address width
//   INDEX_WIDTH  : log2 of line count
//   OFFSET_WIDTH : log2 of 32-bit words per line
//   TAG_WIDTH    : remaining upper address bits
package cache_pkg;
  localparam int ADDR_WIDTH   = 32;
  localparam int INDEX_WIDTH  = 6;
  localparam int OFFSET_WIDTH = 2;
  localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH - 2;

  typedef logic [1:0] state_t;
  localparam state_t IDLE    = 2'd0;
  localparam state_t REFILL  = 2'd1;
  localparam state_t RESPOND = 2'd2;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]    tag;
    logic [INDEX_WIDTH-1:0]  index;
    logic [OFFSET_WIDTH-1:0] offset;
  } addr_fields_t;

  // Takes the word address (byte address without its two low bits).
  function automatic addr_fields_t split_addr(input logic [ADDR_WIDTH-1:2] word_addr);
    return addr_fields_t'(word_addr);
  endfunction
endpackage

// File: rtl/icache_line_ram.sv
// icache_line_ram: tag, valid and data storage for the direct-mapped instruction cache
//   clk, rst_n              : clock; async active-low clear of the valid bits only
//   i_rd_index/i_rd_offset  : combinational lookup of one line's valid/tag and one word
//   o_rd_valid/o_rd_tag/o_rd_word : lookup results
//   i_wr_en/i_wr_index/i_wr_offset/i_wr_word : synchronous word write
//   i_tag_we/i_wr_tag       : synchronous tag write that also marks the line valid
module icache_line_ram
  import cache_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [INDEX_WIDTH-1:0]  i_rd_index,
  input  logic [OFFSET_WIDTH-1:0] i_rd_offset,
  output logic                    o_rd_valid,
  output logic [TAG_WIDTH-1:0]    o_rd_tag,
  output logic [31:0]             o_rd_word,
  input  logic                    i_wr_en,
  input  logic [INDEX_WIDTH-1:0]  i_wr_index,
  input  logic [OFFSET_WIDTH-1:0] i_wr_offset,
  input  logic [31:0]             i_wr_word,
  input  logic                    i_tag_we,
  input  logic [TAG_WIDTH-1:0]    i_wr_tag
);
  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int WORDS = 1 << OFFSET_WIDTH;

  logic [LINES-1:0]     r_valid;
  logic [TAG_WIDTH-1:0] r_tag  [LINES];
  logic [31:0]          r_data [LINES][WORDS];

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_word  = r_data[i_rd_index][i_rd_offset];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_valid <= '0;
    else if (i_tag_we) r_valid[i_wr_index] <= 1'b1;

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_data[i_wr_index][i_wr_offset] <= i_wr_word;
    if (i_tag_we) r_tag[i_wr_index] <= i_wr_tag;
  end
endmodule

// File: rtl/instruction_cache.sv
// instruction_cache: direct-mapped read-only I-cache between the instruction fetcher and memory
//   Sys_clk / Sys_rst / Sys_rdy : clock, async active-low reset, global enable (0 freezes all state)
//   IFIC_en / IFIC_pc           : level fetch request and its byte address
//   ICIF_en / ICIF_data / ICIF_pc : one-cycle response pulse, instruction word, word address
//   RoBIC_flush                 : redirect; squashes any response not yet delivered
//   ICMC_en / ICMC_addr         : word read request to the memory controller, held until served
//   MCIC_en / MCIC_data         : memory controller word-valid pulse and data
module instruction_cache
  import cache_pkg::*;
(
  input  logic                  Sys_clk,
  input  logic                  Sys_rst,
  input  logic                  Sys_rdy,
  input  logic                  IFIC_en,
  input  logic [ADDR_WIDTH-1:0] IFIC_pc,
  output logic                  ICIF_en,
  output logic [31:0]           ICIF_data,
  output logic [ADDR_WIDTH-1:0] ICIF_pc,
  input  logic                  RoBIC_flush,
  output logic                  ICMC_en,
  output logic [ADDR_WIDTH-1:0] ICMC_addr,
  input  logic                  MCIC_en,
  input  logic [31:0]           MCIC_data
);
  state_t                  r_state, w_next_state;
  logic                    r_icif_en, r_icmc_en, r_drop;
  logic [31:0]             r_icif_data, r_word;
  logic [ADDR_WIDTH-1:0]   r_icif_pc, r_icmc_addr, r_req_pc;
  logic [OFFSET_WIDTH-1:0] r_cnt;

  addr_fields_t            w_in, w_fill;
  logic                    w_rd_valid, w_hit, w_accept, w_start, w_mc_word, w_last;
  logic [TAG_WIDTH-1:0]    w_rd_tag;
  logic [31:0]             w_rd_word;

  logic                    w_icif_en_n, w_icmc_en_n, w_drop_n;
  logic [31:0]             w_icif_data_n, w_word_n;
  logic [ADDR_WIDTH-1:0]   w_icif_pc_n, w_icmc_addr_n, w_req_pc_n;
  logic [OFFSET_WIDTH-1:0] w_cnt_n;

  assign w_in   = split_addr(IFIC_pc[ADDR_WIDTH-1:2]);
  assign w_fill = split_addr(r_req_pc[ADDR_WIDTH-1:2]);

  icache_line_ram u_ram (
    .clk        (Sys_clk),
    .rst_n      (Sys_rst),
    .i_rd_index (w_in.index),
    .i_rd_offset(w_in.offset),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_word  (w_rd_word),
    .i_wr_en    (w_mc_word && Sys_rdy),
    .i_wr_index (w_fill.index),
    .i_wr_offset(r_cnt),
    .i_wr_word  (MCIC_data),
    .i_tag_we   (w_mc_word && w_last && Sys_rdy),
    .i_wr_tag   (w_fill.tag)
  );

  // The ICIF_en term leaves a bubble after each response: the fetcher only
  // presents its next pc on the edge that consumes the current one.
  assign w_hit     = w_rd_valid && (w_rd_tag == w_in.tag);
  assign w_accept  = (r_state == IDLE) && IFIC_en && !RoBIC_flush && !r_icif_en;
  assign w_start   = w_accept && !w_hit;
  // Memory words outside REFILL are stray and dropped.
  assign w_mc_word = (r_state == REFILL) && MCIC_en;
  assign w_last    = &r_cnt;

  always_ff @(posedge Sys_clk or negedge Sys_rst)
    if (!Sys_rst) r_state <= IDLE;
    else if (Sys_rdy) r_state <= w_next_state;

  always_comb begin
    w_next_state = r_state;
    if (w_start) w_next_state = REFILL;
    if (w_mc_word && w_last) w_next_state = RESPOND;
    if (r_state == RESPOND) w_next_state = IDLE;
  end

  // A refill always runs to completion so the line is installed even when
  // its response has been squashed by a flush.
  always_comb begin
    w_icif_en_n   = (w_accept && w_hit) || ((r_state == RESPOND) && !r_drop && !RoBIC_flush);
    w_icif_data_n = (r_state == RESPOND) ? r_word : w_rd_word;
    w_icif_pc_n   = (r_state == RESPOND) ? r_req_pc : IFIC_pc;
    w_icmc_en_n   = w_start ? 1'b1 : (w_mc_word && w_last) ? 1'b0 : r_icmc_en;
    w_icmc_addr_n = w_start ? {w_in.tag, w_in.index, {(OFFSET_WIDTH + 2){1'b0}}}
                  : (w_mc_word && !w_last) ? r_icmc_addr + ADDR_WIDTH'(4) : r_icmc_addr;
    w_cnt_n       = w_start ? '0 : w_mc_word ? r_cnt + 1'b1 : r_cnt;
    w_drop_n      = (w_start || (r_state == RESPOND)) ? 1'b0 : RoBIC_flush ? 1'b1 : r_drop;
    w_word_n      = (w_mc_word && (r_cnt == w_fill.offset)) ? MCIC_data : r_word;
    w_req_pc_n    = w_start ? IFIC_pc : r_req_pc;
  end

  always_ff @(posedge Sys_clk or negedge Sys_rst)
    if (!Sys_rst) begin
      r_icif_en   <= 1'b0;
      r_icif_data <= '0;
      r_icif_pc   <= '0;
      r_icmc_en   <= 1'b0;
      r_icmc_addr <= '0;
      r_cnt       <= '0;
      r_drop      <= 1'b0;
      r_word      <= '0;
      r_req_pc    <= '0;
    end else if (Sys_rdy) begin
      r_icif_en <= w_icif_en_n;
      if (w_icif_en_n) begin
        r_icif_data <= w_icif_data_n;
        r_icif_pc   <= w_icif_pc_n;
      end
      r_icmc_en   <= w_icmc_en_n;
      r_icmc_addr <= w_icmc_addr_n;
      r_cnt       <= w_cnt_n;
      r_drop      <= w_drop_n;
      r_word      <= w_word_n;
      r_req_pc    <= w_req_pc_n;
    end

  assign ICIF_en   = r_icif_en;
  assign ICIF_data = r_icif_data;
  assign ICIF_pc   = r_icif_pc;
  assign ICMC_en   = r_icmc_en;
  assign ICMC_addr = r_icmc_addr;
endmodule

// File: tb/tb_instruction_cache.sv
`timescale 1ns/1ps
module tb_instruction_cache;
  logic        Sys_clk = 0, Sys_rst = 0, Sys_rdy = 1, IFIC_en = 0, RoBIC_flush = 0;
  logic [31:0] IFIC_pc = 0;
  logic        ICIF_en, ICMC_en, MCIC_en;
  logic [31:0] ICIF_data, ICIF_pc, ICMC_addr, MCIC_data;
  logic        mc_go = 0, stray = 0, prev_en = 0;
  logic [31:0] mc_data = 0;
  int          n_vec = 0, n_err = 0, adj = 0;

  logic [31:0] mem  [logic [31:0]];
  logic [31:0] snap [logic [31:0]];
  logic [31:0] mc_log [$];
  bit          res_ok   [64];
  logic [31:0] res_base [64];

  instruction_cache dut (
    .Sys_clk    (Sys_clk),
    .Sys_rst    (Sys_rst),
    .Sys_rdy    (Sys_rdy),
    .IFIC_en    (IFIC_en),
    .IFIC_pc    (IFIC_pc),
    .ICIF_en    (ICIF_en),
    .ICIF_data  (ICIF_data),
    .ICIF_pc    (ICIF_pc),
    .RoBIC_flush(RoBIC_flush),
    .ICMC_en    (ICMC_en),
    .ICMC_addr  (ICMC_addr),
    .MCIC_en    (MCIC_en),
    .MCIC_data  (MCIC_data)
  );

  always #5 Sys_clk = ~Sys_clk;

  assign MCIC_en   = mc_go | stray;
  assign MCIC_data = stray ? 32'hDEAD_BEEF : mc_data;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a * 32'h9E37_79B1) ^ 32'h0F0F_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory controller: serves the currently requested word after a random gap.
  always @(negedge Sys_clk) begin
    mc_go   = ICMC_en && ($urandom_range(0, 3) != 0);
    mc_data = mem_rd(ICMC_addr);
    if (ICIF_en && prev_en) adj++;
    prev_en = ICIF_en;
  end

  always @(posedge Sys_clk)
    if (MCIC_en && ICMC_en && Sys_rdy && Sys_rst) mc_log.push_back(ICMC_addr);

  task automatic clear_model();
    foreach (res_ok[i]) res_ok[i] = 0;
  endtask

  // One request: miss/hit and data predicted from the resident-line model.
  task automatic fetch(input logic [31:0] pc, input int flush_at, input int stall_at);
    logic [31:0] base, exp_d, a0;
    int idx, start, n, got, w0, post, fl;
    bit hit, killed, stalled;
    base = pc & ~32'hF;
    idx = int'(pc[9:4]);
    hit = res_ok[idx] && res_base[idx] == base;
    exp_d = hit ? snap[pc & ~32'h3] : mem_rd(pc & ~32'h3);
    killed = !hit && flush_at >= 0;
    fl = hit ? -1 : flush_at;
    start = mc_log.size();
    got = 0; n = 0; post = 0; stalled = 0;
    @(negedge Sys_clk);
    IFIC_en = 1;
    IFIC_pc = pc;
    while (n < 200) begin
      @(negedge Sys_clk);
      n++;
      IFIC_en = 0;
      RoBIC_flush = 0;
      if (ICIF_en) begin
        got++;
        check("resp_data", ICIF_data, exp_d);
        check("resp_pc", ICIF_pc, pc);
        if (hit) check("hit_latency", n, 1);
      end
      if (hit && n == 1) check("hit_no_mc", ICMC_en, 0);
      if (fl >= 0 && mc_log.size() - start == fl) begin
        RoBIC_flush = 1;
        fl = -2;
      end
      if (!hit && stall_at >= 0 && !stalled && mc_log.size() - start == stall_at) begin
        stalled = 1;
        a0 = ICMC_addr;
        w0 = mc_log.size();
        Sys_rdy = 0;
        repeat (3) begin
          @(negedge Sys_clk);
          check("rdy_addr_frozen", ICMC_addr, a0);
          check("rdy_words_frozen", mc_log.size(), w0);
        end
        Sys_rdy = 1;
      end
      if (killed && mc_log.size() - start >= 4) post++;
      if (got > 0 || post > 3) break;
    end
    if (n >= 200) check("timeout", n, 0);
    check(killed ? "flush_no_resp" : "resp_count", got, killed ? 0 : 1);
    check("refill_words", mc_log.size() - start, hit ? 0 : 4);
    for (int k = 0; k < 4 && start + k < mc_log.size(); k++)
      check("refill_addr", mc_log[start + k], base + 32'(4 * k));
    if (!hit) begin
      res_ok[idx] = 1;
      res_base[idx] = base;
      for (int k = 0; k < 4; k++) snap[base + 32'(4 * k)] = mem_rd(base + 32'(4 * k));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] pcs [3];
    int k, n, last, s;
    for (int i = 0; i < 4; i++) mem[32'h100 + 32'(4 * i)] = 32'h11 * 32'(i + 1);
    clear_model();
    #12;
    check("rst_icif_en", ICIF_en, 0);
    check("rst_icif_data", ICIF_data, 0);
    check("rst_icif_pc", ICIF_pc, 0);
    check("rst_icmc_en", ICMC_en, 0);
    check("rst_icmc_addr", ICMC_addr, 0);
    @(negedge Sys_clk);
    Sys_rst = 1;

    fetch(32'h104, -1, -1);
    fetch(32'h10C, -1, -1);

    fetch(32'h500, -1, -1);
    for (int i = 0; i < 4; i++) mem[32'h100 + 32'(4 * i)] = 32'hA1 + 32'(i);
    fetch(32'h100, -1, -1);

    fetch(32'h200, 1, -1);
    fetch(32'h204, -1, -1);

    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
    k = 0; n = 0; last = 0;
    @(negedge Sys_clk);
    IFIC_en = 1;
    IFIC_pc = pcs[0];
    while (k < 3 && n < 50) begin
      @(negedge Sys_clk);
      n++;
      if (ICIF_en) begin
        check("b2b_data", ICIF_data, snap[pcs[k]]);
        check("b2b_pc", ICIF_pc, pcs[k]);
        if (k > 0) check("b2b_gap", n - last, 2);
        last = n;
        k++;
        if (k < 3) IFIC_pc = pcs[k];
        else IFIC_en = 0;
      end
    end
    IFIC_en = 0;
    check("b2b_count", k, 3);

    @(negedge Sys_clk);
    stray = 1;
    @(negedge Sys_clk);
    stray = 0;
    check("stray_no_resp", ICIF_en, 0);
    fetch(32'h200, -1, -1);

    fetch(32'h300, -1, 2);

    s = mc_log.size();
    @(negedge Sys_clk);
    IFIC_en = 1;
    IFIC_pc = 32'h700;
    @(negedge Sys_clk);
    IFIC_en = 0;
    n = 0;
    while (mc_log.size() - s < 1 && n < 50) begin
      @(negedge Sys_clk);
      n++;
    end
    #2 Sys_rst = 0;
    #1;
    check("arst_icif_en", ICIF_en, 0);
    check("arst_icif_data", ICIF_data, 0);
    check("arst_icif_pc", ICIF_pc, 0);
    check("arst_icmc_en", ICMC_en, 0);
    check("arst_icmc_addr", ICMC_addr, 0);
    @(negedge Sys_clk);
    Sys_rst = 1;
    clear_model();
    fetch(32'h104, -1, -1);

    for (int i = 0; i < 40; i++)
      fetch((32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4) |
            (32'($urandom_range(0, 3)) << 2),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1, -1);

    check("never_adjacent", adj, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/instruction_cache.md
Name: instruction_cache

Overview:
- Direct-mapped, read-only instruction cache sitting directly upstream of InstructionFetcher.
- Serves 32-bit instruction words to the fetcher, one request at a time.
- On a miss, refills a whole line word-by-word from the memory controller.
- Honours a pipeline flush from RoB so that fetches on a squashed path are not delivered.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- INDEX_WIDTH, 6, log2 of line count (64 lines).
- OFFSET_WIDTH, 2, log2 of words per line (4 words = 16 bytes).
- TAG_WIDTH, ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH-2, derived; not overridable.

Ports:
- Sys_clk  in  1  single clock, rising edge.
- Sys_rst  in  1  asynchronous, active-low reset (0 = reset).
- Sys_rdy  in  1  global enable; when 0 all state holds.
- IFIC_en  in  1  level request from fetcher.
- IFIC_pc  in  ADDR_WIDTH  request address; bits [1:0] ignored.
- ICIF_en  out  1  one-cycle response-valid pulse.
- ICIF_data  out  32  instruction word; held stable until the next response.
- ICIF_pc  out  ADDR_WIDTH  address of the word in ICIF_data.
- RoBIC_flush  in  1  misprediction/jalr redirect; kills any pending response.
- ICMC_en  out  1  word-read request to memory controller; level, held until acknowledged.
- ICMC_addr  out  ADDR_WIDTH  word-aligned read address.
- MCIC_en  in  1  memory controller word-valid pulse.
- MCIC_data  in  32  returned word.

Behaviour:
- Reset (Sys_rst=0, async):
  - All valid bits cleared; state=IDLE.
  - ICIF_en=0, ICIF_data=0, ICIF_pc=0, ICMC_en=0, ICMC_addr=0, drop flag=0.
  - Tag/data arrays are not reset.
- Sys_rdy=0: no register changes, including valid, counter and state.
- Address split: offset=pc[OFFSET_WIDTH+1:2], index=next INDEX_WIDTH bits, tag=remaining upper bits.
- States: IDLE, REFILL, RESPOND.
- IDLE:
  - Accepts a request when IFIC_en=1, RoBIC_flush=0 and ICIF_en=0 in that cycle. The one-cycle bubble exists because the fetcher updates IFIC_pc on the edge where it consumes ICIF_en.
  - Hit (valid[index] and tag match, combinational lookup): next edge registers ICIF_en=1, ICIF_data=word, ICIF_pc=IFIC_pc. Hit latency = 1 cycle.
  - Miss: latch pc into req_pc, word counter=0, drop=0, ICMC_en=1, ICMC_addr={tag,index,0..0}; go to REFILL.
- REFILL:
  - On MCIC_en: write MCIC_data into data[index][counter].
  - If counter == req offset, capture the word into a response register.
  - If the counter is not at its last value: counter+1, ICMC_addr+4, ICMC_en stays 1.
  - If the counter is at its last value: ICMC_en=0, write tag, set valid[index], go to RESPOND.
  - Refill always completes even after a flush; the line is still installed.
- RESPOND (one cycle):
  - If drop=0 and RoBIC_flush=0: ICIF_en=1 with the captured word and req_pc.
  - Then return to IDLE.
- Flush:
  - RoBIC_flush=1 in any state sets drop=1 (or, in IDLE, blocks acceptance).
  - A hit accepted the same cycle as a flush is not accepted.
  - drop clears on entry to REFILL and on exit from RESPOND.
- ICIF_en never asserts two consecutive cycles; at most one request is outstanding.
- Memory-controller responses while not in REFILL are ignored; this is a protocol error that the bench must flag.
- ICIF_data/ICIF_pc change only on the edge that asserts ICIF_en.

Decomposition:
- Shared package `cache_pkg` holds:
  - width constants (ADDR_WIDTH, INDEX_WIDTH, OFFSET_WIDTH, TAG_WIDTH);
  - state encoding localparams IDLE/REFILL/RESPOND;
  - an address-field extraction helper, also reusable by a future data cache.
- One sub-module `icache_line_ram`:
  - Holds the tag array, valid bits and data array.
  - Interface: combinational read by index, synchronous word write and tag/valid write.
  - Async-low clear of valid bits.
- The controller FSM stays in the top module.

Test Plan:
- Cold miss:
  - Stimulus: after reset, IFIC_en=1, IFIC_pc=0x0000_0104. The memory model returns 0x11,0x22,0x33,0x44 for 0x100..0x10C.
  - Required: ICMC_addr sequence 0x100,0x104,0x108,0x10C, then exactly one ICIF_en with data=0x22 and ICIF_pc=0x104.
- Hit after fill:
  - Stimulus: request 0x10C.
  - Required: ICIF_en one cycle later, data=0x44, ICMC_en stays 0.
- Conflict eviction:
  - Stimulus: fill 0x100, then request 0x500 (same index, different tag), then 0x100.
  - Required: both later requests miss and refill; the final data is from the refetched line.
- Flush during refill:
  - Stimulus: miss on 0x200, assert RoBIC_flush during the 2nd word.
  - Required: all 4 words are still fetched and no ICIF_en is emitted. A later request to 0x204 hits in 1 cycle.
- Back-to-back hits:
  - Stimulus: IFIC_en held at 1, pc stepping 0x100,0x104,0x108.
  - Required: ICIF_en pulses every 2 cycles, never adjacent.
- Sys_rdy / reset:
  - Stimulus 1: Sys_rdy=0 for 3 cycles mid-refill. Required: ICMC_addr and the counter are frozen, and the refill resumes correctly.
  - Stimulus 2: Sys_rst pulsed low mid-refill. Required: outputs are 0 immediately, and a prior hit address now misses.
